// File: rtl/tron_dir_input_if.sv
// Bus bundle for tron_dir_input: active-low button nibbles and enable in,
// one-hot directions and per-player change strobes out.
interface tron_dir_input_if #(
  parameter int NUM_PLAYERS = 2
);
  logic [4*NUM_PLAYERS-1:0] data;
  logic                     enable;
  logic [5*NUM_PLAYERS-1:0] dir;
  logic [NUM_PLAYERS-1:0]   dir_change;

  modport master (
    output data,
    output enable,
    input  dir,
    input  dir_change
  );

  modport slave (
    input  data,
    input  enable,
    output dir,
    output dir_change
  );
endinterface

// File: rtl/tron_dir_input.sv
// Per-player Tron direction input: synchronise, debounce, decode one-hot direction.
// Define TRON_NO_REVERSE_EN to ignore 180-degree reversal requests.
module tron_dir_input #(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  tron_dir_input_if.slave  bus
);

  localparam int                CNT_W   = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [4:0]        DIR_IDLE = 5'b00001;

  logic [5*NUM_PLAYERS-1:0] dir_all;
  logic [NUM_PLAYERS-1:0]   change_all;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [3:0]       sync1_reg, sync2_reg, last_reg;
      logic [3:0]       stable_reg, stable_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next, run;
      logic [4:0]       dir_reg, dir_next;
      logic             dir_change_reg, change_next;
      logic [4:0]       req;
      logic             req_valid;
      logic             blocked;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg      <= '0;
          sync2_reg      <= '0;
          last_reg       <= '0;
          stable_reg     <= '0;
          cnt_reg        <= '0;
          dir_reg        <= DIR_IDLE;
          dir_change_reg <= 1'b0;
        end else begin
          sync1_reg      <= ~bus.data[4*gi +: 4];
          sync2_reg      <= sync1_reg;
          last_reg       <= sync2_reg;
          stable_reg     <= stable_next;
          cnt_reg        <= cnt_next;
          dir_reg        <= dir_next;
          dir_change_reg <= change_next;
        end
      end

      // run = consecutive edges the synchronised pattern has differed from
      // stable while holding one value; a new value restarts it at 1.
      always_comb begin
        stable_next = stable_reg;
        cnt_next    = '0;
        run         = '0;
        if (sync2_reg != stable_reg) begin
          if (sync2_reg != last_reg)
            run = CNT_W'(1);
          else if (cnt_reg >= CNT_MAX)
            run = CNT_MAX;
          else
            run = cnt_reg + CNT_W'(1);
          if (run >= CNT_MAX)
            stable_next = sync2_reg;
          else
            cnt_next = run;
        end
      end

      always_comb begin
        req       = DIR_IDLE;
        req_valid = 1'b0;
        case (stable_reg)
          4'b0001: begin req = 5'b00010; req_valid = 1'b1; end
          4'b0010: begin req = 5'b10000; req_valid = 1'b1; end
          4'b0100: begin req = 5'b01000; req_valid = 1'b1; end
          4'b1000: begin req = 5'b00100; req_valid = 1'b1; end
          default: begin req = DIR_IDLE; req_valid = 1'b0; end
        endcase
      end

`ifdef TRON_NO_REVERSE_EN
      // Opposite of req: swap up/down and left/right; idle never matches.
      assign blocked = req_valid && (dir_reg == {req[3], req[4], req[1], req[2], 1'b0});
`else
      assign blocked = 1'b0;
`endif

      always_comb begin
        change_next = bus.enable && req_valid && (req != dir_reg) && !blocked;
        dir_next    = change_next ? req : dir_reg;
      end

      assign dir_all[5*gi +: 5] = dir_reg;
      assign change_all[gi]     = dir_change_reg;
    end
  endgenerate

  assign bus.dir        = dir_all;
  assign bus.dir_change = change_all;

endmodule

// File: tb/tb_tron_dir_input.sv
// Directed testbench for tron_dir_input with NUM_PLAYERS=2, DEBOUNCE_CYCLES=4.
module tb_tron_dir_input;

  logic clk;
  logic reset;
  int   err_cnt;
  int   chk_cnt;
  int   strobes;
  logic [4:0] p0_exp;

  tron_dir_input_if #(.NUM_PLAYERS(2)) bus ();

  tron_dir_input #(
    .NUM_PLAYERS     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    err_cnt    = 0;
    chk_cnt    = 0;
    reset      = 1'b0;
    bus.data   = 8'hFF;
    bus.enable = 1'b1;

    // 1. asynchronous reset mid-cycle
    #12 reset = 1'b1;
    #1;
    check("rst_dir", 16'(bus.dir), 16'b00001_00001);
    check("rst_chg", 16'(bus.dir_change), 16'h0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("idle_dir", 16'(bus.dir), 16'b00001_00001);
    check("idle_chg", 16'(bus.dir_change), 16'h0);

    // 2. clean press: up on player 0, update on edge 6 only
    bus.data[3:0] = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 6) begin
        check($sformatf("lat_dir_e%0d", i), 16'(bus.dir), 16'b00001_00001);
        check($sformatf("lat_chg_e%0d", i), 16'(bus.dir_change), 16'h0);
      end else if (i == 6) begin
        check("up_dir", 16'(bus.dir), 16'b00001_10000);
        check("up_chg", 16'(bus.dir_change), 16'b01);
      end else begin
        check($sformatf("hold_chg_e%0d", i), 16'(bus.dir_change), 16'h0);
      end
    end
    bus.data[3:0] = 4'hF;
    for (int i = 0; i < 10; i++) step();
    check("release_dir", 16'(bus.dir), 16'b00001_10000);

    // 3. glitch then chord on player 1
    strobes = 0;
    bus.data[7:4] = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.dir_change != 0) strobes++;
    end
    bus.data[7:4] = 4'hF;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.dir_change != 0) strobes++;
    end
    check("glitch_strobes", 16'(strobes), 16'd0);
    check("glitch_dir", 16'(bus.dir), 16'b00001_10000);
    strobes = 0;
    bus.data[7:4] = 4'b1100;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.dir_change != 0) strobes++;
    end
    check("chord_strobes", 16'(strobes), 16'd0);
    check("chord_dir", 16'(bus.dir), 16'b00001_10000);
    bus.data[7:4] = 4'hF;
    for (int i = 0; i < 10; i++) step();

    // 4. reversal up -> down on player 0
    strobes = 0;
    bus.data[3:0] = 4'b1011;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.dir_change[0]) strobes++;
    end
`ifdef TRON_NO_REVERSE_EN
    p0_exp = 5'b10000;
    check("rev_strobes", 16'(strobes), 16'd0);
`else
    p0_exp = 5'b01000;
    check("rev_strobes", 16'(strobes), 16'd1);
`endif
    check("rev_dir", 16'(bus.dir), 16'({5'b00001, p0_exp}));
    bus.data[3:0] = 4'hF;
    for (int i = 0; i < 10; i++) step();

    // 5. enable gating: left on player 1 held while disabled
    strobes = 0;
    bus.enable = 1'b0;
    bus.data[7:4] = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.dir_change != 0) strobes++;
    end
    check("gate_strobes", 16'(strobes), 16'd0);
    check("gate_dir", 16'(bus.dir), 16'({5'b00001, p0_exp}));
    bus.enable = 1'b1;
    step();
    check("en_dir", 16'(bus.dir), 16'({5'b00100, p0_exp}));
    check("en_chg", 16'(bus.dir_change), 16'b10);
    step();
    check("en_chg_off", 16'(bus.dir_change), 16'h0);

    // 6. reset two edges into a press; both players re-debounce together
    bus.data[3:0] = 4'b1110;
    step();
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_dir", 16'(bus.dir), 16'b00001_00001);
    check("mid_rst_chg", 16'(bus.dir_change), 16'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i < 6) begin
        check($sformatf("rlat_dir_e%0d", i), 16'(bus.dir), 16'b00001_00001);
      end else if (i == 6) begin
        check("rlat_dir", 16'(bus.dir), 16'b00100_00010);
        check("rlat_chg", 16'(bus.dir_change), 16'b11);
      end else begin
        check("rlat_chg_off", 16'(bus.dir_change), 16'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
